// File: rtl/addsub_arbiter.sv
// Two-requester arbiter around a shared 16-bit saturating add/subtract unit.
// Optional `ADDSUB_ARB_RR_EN selects round-robin tie-breaking (fixed priority otherwise).

module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] Sat_Sum,
  output logic        Ovfl
);
  logic [15:0] bx;
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] sum;
  logic [16:0] c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;

  // cin doubles as the subtract select: A - B = A + ~B + 1
  assign bx = b ^ {16{cin}};
  assign g  = a & bx;
  assign p  = a ^ bx;

  for (genvar j = 0; j < 4; j++) begin : g_grp
    assign grp_g[j] = g[4*j+3]
                    | (p[4*j+3] & g[4*j+2])
                    | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                    | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    assign grp_p[j] = &p[4*j +: 4];
  end

  assign grp_c[0] = cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
  assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

  for (genvar j = 0; j < 4; j++) begin : g_bitc
    assign c[4*j] = grp_c[j];
    for (genvar i = 0; i < 3; i++) begin : g_in
      assign c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
    end
  end
  assign c[16] = grp_c[4];

  assign sum  = p ^ c[15:0];
  assign Ovfl = c[16] ^ c[15];
  // On overflow the true result has the sign of A in both add and subtract
  assign Sat_Sum = Ovfl ? (a[15] ? 16'h8000 : 16'h7FFF) : sum;
endmodule

module addsub_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_ovfl,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             tie_pick1;
  logic             grant0;
  logic             grant1;
  logic             accept_win;
  logic             hs0;
  logic             hs1;
  logic             hs;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             op_id;
  logic [WIDTH-1:0] cla_sum;
  logic             cla_ovfl;

`ifdef ADDSUB_ARB_RR_EN
  assign tie_pick1 = ~last_grant;
`else
  // Fixed priority: last_grant is still tracked but can never win a tie
  assign tie_pick1 = last_grant & 1'b0;
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = ~tie_pick1;
      grant1 = tie_pick1;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Gated by rst_n so readies stay low throughout reset, even before state is known
  assign accept_win = rst_n & ((state == IDLE) | ((state == RESP) & rsp_ready));
  assign req0_ready = grant0 & accept_win;
  assign req1_ready = grant1 & accept_win;
  assign hs0        = req0_valid & req0_ready;
  assign hs1        = req1_valid & req1_ready;
  assign hs         = hs0 | hs1;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = hs ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_sub     <= 1'b0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
    end else if (hs) begin
      op_a       <= hs1 ? req1_a   : req0_a;
      op_b       <= hs1 ? req1_b   : req0_b;
      op_sub     <= hs1 ? req1_sub : req0_sub;
      op_id      <= hs1;
      last_grant <= hs1;
    end
  end

  cla_16bit u_cla (
    .a       (op_a),
    .b       (op_b),
    .cin     (op_sub),
    .Sat_Sum (cla_sum),
    .Ovfl    (cla_ovfl)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_ovfl  <= 1'b0;
      rsp_id    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= cla_sum;
      rsp_ovfl  <= cla_ovfl;
      rsp_id    <= op_id;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: transaction-level model plus directed and random steps.

module tb_addsub_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic        rsp_valid, rsp_id, rsp_ovfl, busy;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_sum;

  int errors = 0;
  int checks = 0;

  // Model: one op computing, one result held; values derived from plain integer arithmetic
  logic        m_lg = 1'b1;
  logic        ex_v = 1'b0, rs_v = 1'b0;
  logic [15:0] ex_s, rs_s = '0;
  logic        ex_o, rs_o = 1'b0, ex_id, rs_id = 1'b0;
  logic        last_hs0, last_hs1;
  int          id_log[$];

  addsub_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_ovfl(rsp_ovfl), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                 output logic [15:0] s, output logic o);
    int r;
    r = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    o = 1'b1;
    if (r > 32767) s = 16'h7FFF;
    else if (r < -32768) s = 16'h8000;
    else begin s = r[15:0]; o = 1'b0; end
  endfunction

  // One clock: check readies before the edge, advance the model, check outputs after it
  task automatic cycle();
    logic win, t1, p0, p1, acc0, acc1, moved;
    #1;
    win = rst_n && !ex_v && (!rs_v || rsp_ready);
    if (req0_valid && req1_valid) begin
`ifdef ADDSUB_ARB_RR_EN
      t1 = (m_lg == 1'b0);
`else
      t1 = 1'b0;
`endif
      p0 = !t1;
      p1 = t1;
    end else begin
      p0 = req0_valid;
      p1 = req1_valid;
    end
    acc0 = p0 & win;
    acc1 = p1 & win;
    check("req0_ready", req0_ready, acc0);
    check("req1_ready", req1_ready, acc1);
    last_hs0 = req0_valid & req0_ready;
    last_hs1 = req1_valid & req1_ready;
    moved = 1'b0;
    @(posedge clk);
    if (!rst_n) begin
      m_lg = 1'b1; ex_v = 1'b0; rs_v = 1'b0; rs_s = '0; rs_o = 1'b0; rs_id = 1'b0;
    end else begin
      if (rs_v && rsp_ready) rs_v = 1'b0;
      if (ex_v) begin
        rs_v = 1'b1; rs_s = ex_s; rs_o = ex_o; rs_id = ex_id; ex_v = 1'b0; moved = 1'b1;
      end
      if (acc0 || acc1) begin
        ex_v = 1'b1;
        ex_id = acc1;
        m_lg = acc1;
        if (acc1) ref_op(req1_a, req1_b, req1_sub, ex_s, ex_o);
        else      ref_op(req0_a, req0_b, req0_sub, ex_s, ex_o);
      end
    end
    #2;
    check("rsp_valid", rsp_valid, rs_v);
    check("busy", busy, ex_v | rs_v);
    if (rs_v) begin
      check("rsp_sum", rsp_sum, rs_s);
      check("rsp_ovfl", rsp_ovfl, rs_o);
      check("rsp_id", rsp_id, rs_id);
    end
    if (moved) id_log.push_back(int'(rsp_id));
  endtask

  // Present one op on a single requester, wait (bounded) for acceptance, then run the EXEC cycle
  task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b, input logic sub);
    bit done = 0;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub; end
    for (int i = 0; i < 10 && !done; i++) begin
      cycle();
      done = id ? last_hs1 : last_hs0;
    end
    check("accept_timeout", done, 1);
    req0_valid = 0; req1_valid = 0;
    req0_a = 16'hDEAD; req1_a = 16'hBEEF;
    cycle();
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    for (int i = 0; i < n; i++) cycle();
    rst_n = 1;
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0001;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] held_sum;
    logic        held_id;
    int          exp_ids[4];

    // Reset with both requesters asserting
    req0_valid = 1; req1_valid = 1;
    req0_a = 16'h0003; req0_b = 16'h0004; req0_sub = 0;
    req1_a = 16'h1111; req1_b = 16'h2222; req1_sub = 0;
    do_reset(2);
    check("reset_sum", rsp_sum, 16'h0000);
    check("reset_ovfl", rsp_ovfl, 0);
    check("reset_id", rsp_id, 0);

    // First tie after reset goes to requester 0
    #1;
    check("first_tie_r0", req0_ready, 1);
    check("first_tie_r1", req1_ready, 0);
    req1_valid = 0;
    run_op(0, 16'h0003, 16'h0004, 0);
    check("add_valid", rsp_valid, 1);
    check("add_sum", rsp_sum, 16'h0007);
    check("add_ovfl", rsp_ovfl, 0);
    check("add_id", rsp_id, 0);
    rsp_ready = 1; cycle(); rsp_ready = 0;

    run_op(1, 16'h7FFF, 16'h0001, 0);
    check("posat_sum", rsp_sum, 16'h7FFF);
    check("posat_ovfl", rsp_ovfl, 1);
    check("posat_id", rsp_id, 1);
    rsp_ready = 1; cycle(); rsp_ready = 0;

    run_op(0, 16'h8000, 16'h0001, 1);
    check("negsat_sum", rsp_sum, 16'h8000);
    check("negsat_ovfl", rsp_ovfl, 1);
    rsp_ready = 1; cycle(); rsp_ready = 0;

    run_op(1, 16'h0005, 16'h0007, 1);
    check("subneg_sum", rsp_sum, 16'hFFFE);
    check("subneg_ovfl", rsp_ovfl, 0);

    // Backpressure: result held, a new request waits until rsp_ready rises
    held_sum = rsp_sum; held_id = rsp_id;
    req0_valid = 1; req0_a = 16'h0100; req0_b = 16'h0023; req0_sub = 0;
    for (int i = 0; i < 3; i++) cycle();
    check("bp_sum_stable", rsp_sum, held_sum);
    check("bp_id_stable", rsp_id, held_id);
    rsp_ready = 1; cycle();
    check("bp_accept_same_cycle", last_hs0, 1);
    req0_valid = 0; rsp_ready = 0;
    cycle();
    check("bp_next_sum", rsp_sum, 16'h0123);
    rsp_ready = 1; cycle(); rsp_ready = 0;

    // Contention: both valid continuously, consumer always ready
    do_reset(1);
    id_log.delete();
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    req0_a = 16'h0010; req0_b = 16'h0001; req1_a = 16'h0020; req1_b = 16'h0002;
    for (int i = 0; i < 9; i++) cycle();
    req0_valid = 0; req1_valid = 0;
    cycle(); cycle();
    rsp_ready = 0;
`ifdef ADDSUB_ARB_RR_EN
    exp_ids = '{0, 1, 0, 1};
`else
    exp_ids = '{0, 0, 0, 0};
`endif
    check("contention_count_ge4", id_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      check($sformatf("contention_id%0d", i), (i < id_log.size()) ? id_log[i] : -1, exp_ids[i]);

    // Reset during EXEC discards the op
    req0_valid = 1; req0_a = 16'h0042; req0_b = 16'h0001; req0_sub = 0;
    cycle();
    check("midrst_accepted", last_hs0, 1);
    req0_valid = 0;
    rst_n = 0; cycle(); rst_n = 1;
    rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("midrst_no_rsp", rsp_valid, 0);
    end
    rsp_ready = 0;
    run_op(1, 16'h1234, 16'h0034, 1);
    check("post_rst_sum", rsp_sum, 16'h1200);
    check("post_rst_id", rsp_id, 1);
    rsp_ready = 1; cycle(); rsp_ready = 0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      req0_a = pick_operand(); req0_b = pick_operand(); req0_sub = 1'($urandom);
      req1_a = pick_operand(); req1_b = pick_operand(); req1_sub = 1'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
